// File: rtl/hevc_qpel_interp_2d.sv
// HEVC luma quarter-pel 2-D interpolator: horizontal 8-tap per input row, 7-row line buffer, vertical 8-tap.
// One output row per accepted row once the buffer holds 7 rows; output latency is 1 cycle.
module hevc_qpel_interp_2d #(
    parameter int BLK_W = 8,
    parameter int BLK_H = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               frac_x,
    input  logic [1:0]               frac_y,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [(BLK_W+7)*8-1:0]   in_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BLK_W*8-1:0]       out_row,
    output logic                     busy,
    output logic                     done
);

    // Tap k lives in bits [8k+7:8k] as a signed byte.
    localparam logic [63:0] F1 = 64'h00_01_FB_11_3A_F6_04_FF;
    localparam logic [63:0] F2 = 64'hFF_04_F5_28_28_F5_04_FF;
    localparam logic [63:0] F3 = 64'hFF_04_F6_3A_11_FB_01_00;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

    state_t                          state;
    logic [6:0]                      cnt;
    logic [1:0]                      fx;
    logic [1:0]                      fy;
    logic [6:0][BLK_W-1:0][15:0]     lb;
    logic [BLK_W-1:0][15:0]          hnew;
    logic [BLK_W*8-1:0]              vout;
    logic [63:0]                     cx;
    logic [63:0]                     cy;
    logic signed [23:0]              hacc;
    logic signed [31:0]              vacc;
    logic signed [31:0]              v;
    logic signed [31:0]              t;
    logic                            accept;

    function automatic logic [63:0] coefs(input logic [1:0] f);
        case (f)
            2'd1:    return F1;
            2'd2:    return F2;
            default: return F3;
        endcase
    endfunction

    assign cx       = coefs(fx);
    assign cy       = coefs(fy);
    assign in_ready = (state == FILL) || ((state == STREAM) && (!out_valid || out_ready));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        hacc = '0;
        hnew = '0;
        for (int c = 0; c < BLK_W; c++) begin
            hacc = '0;
            for (int k = 0; k < 8; k++) begin
                hacc = hacc + 24'(signed'(cx[8*k +: 8])) *
                              24'(signed'({1'b0, in_row[8*(c+k) +: 8]}));
            end
            hnew[c] = (fx == 2'd0) ? {2'b00, in_row[8*(c+3) +: 8], 6'b000000} : hacc[15:0];
        end
    end

    // Vertical taps 0..6 come from the line buffer (oldest first), tap 7 is the row arriving now.
    always_comb begin
        vacc = '0;
        v    = '0;
        t    = '0;
        vout = '0;
        for (int c = 0; c < BLK_W; c++) begin
            vacc = '0;
            for (int k = 0; k < 7; k++) begin
                vacc = vacc + 32'(signed'(cy[8*k +: 8])) * 32'(signed'(lb[k][c]));
            end
            vacc = vacc + 32'(signed'(cy[63:56])) * 32'(signed'(hnew[c]));
            v    = (fy == 2'd0) ? 32'(signed'(lb[3][c])) : (vacc >>> 6);
            t    = (v + 32) >>> 6;
            if (t < 0)
                vout[8*c +: 8] = 8'd0;
            else if (t > 255)
                vout[8*c +: 8] = 8'd255;
            else
                vout[8*c +: 8] = t[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            fx        <= '0;
            fy        <= '0;
            lb        <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept)
                lb <= {hnew, lb[6:1]};
            case (state)
                IDLE: begin
                    if (start) begin
                        fx    <= frac_x;
                        fy    <= frac_y;
                        cnt   <= '0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        cnt <= cnt + 7'd1;
                        if (cnt == 7'd6)
                            state <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        out_row   <= vout;
                        out_valid <= 1'b1;
                        cnt       <= cnt + 7'd1;
                        if (cnt == 7'(BLK_H + 6))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hevc_qpel_interp_2d.md
Name: hevc_qpel_interp_2d

Overview:
- Parametrised successor of the horizontal-only subpixel interpolator: a full 2-D HEVC luma quarter-pel interpolator for one BLK_W x BLK_H prediction block.
- Accepts one reference row of (BLK_W+7) pixels per handshake beat and filters it horizontally at fractional position frac_x.
- Keeps the last 7 horizontal results in an internal line buffer and filters vertically at frac_y.
- Emits one row of BLK_W clipped 8-bit pixels per output beat. Sits between the reference-fetch buffer and the prediction/residual adder.

Parameters:
- BLK_W, 8, output pixels per row (4..64).
- BLK_H, 8, output rows per block (4..64).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a block when idle; frac_x and frac_y are latched on this cycle.
- frac_x  input  2  horizontal fraction: 0 integer, 1 quarter, 2 half, 3 three-quarter.
- frac_y  input  2  vertical fraction, same encoding.
- in_valid  input  1  in_row is valid.
- in_ready  output  1  block accepts in_row this cycle.
- in_row  input  (BLK_W+7)*8  reference row; pixel j occupies bits [8j+7:8j].
- out_valid  output  1  out_row is valid.
- out_ready  input  1  downstream accepts out_row.
- out_row  output  BLK_W*8  interpolated row; pixel c occupies bits [8c+7:8c].
- busy  output  1  a block is in progress.
- done  output  1  one-cycle pulse after the last output row is accepted.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_row=0, busy=0, done=0. Counters, latched fractions and the line buffer are cleared.
- Coefficient sets, taps 0..7:
  - f1 = -1,4,-10,58,17,-5,1,0
  - f2 = -1,4,-11,40,40,-11,4,-1
  - f3 = 0,1,-5,17,58,-10,4,-1
- Horizontal stage, per column c (0..BLK_W-1), result h[c] is 16-bit signed:
  - frac_x=0: h[c] = pixel[c+3] << 6.
  - Otherwise: h[c] = sum over k of f[k] * pixel[c+k].
- Vertical stage: output row r uses h-rows r..r+7 (h-row i is the result of input row i).
  - frac_y=0: v = hrow[r+3].
  - Otherwise: v = (sum over k of f[k] * hrow[r+k]) >>> 6, arithmetic shift, with at least 24-bit accumulation.
- Final value: out = clip((v + 32) >>> 6, 0, 255).
- Row flow: every block consumes exactly BLK_H+7 input rows, in the order received.
- FSM states and transitions:
  - IDLE -> FILL on start.
  - FILL: accepts rows 0..6 into the line buffer and produces no output. After row 6 -> STREAM.
  - STREAM: each accepted row i (7 <= i <= BLK_H+6) produces output row i-7 in out_row, with out_valid=1 on the next cycle. Latency is 1 cycle from the accepting edge.
  - After row BLK_H+6 is accepted -> DRAIN.
  - DRAIN: waits for the final out_valid && out_ready, then pulses done and returns to IDLE.
- Handshake:
  - in_ready = (state is FILL) or (state is STREAM and (!out_valid or out_ready)).
  - A row is accepted when in_valid && in_ready.
  - out_row holds stable while out_valid && !out_ready.
  - Accepting a new row and popping the held output row in the same cycle is allowed; full throughput is 1 row per cycle.
- Boundaries and error cases:
  - start while busy is ignored; fractions are not re-latched.
  - in_valid in IDLE is ignored and in_ready stays 0.
  - frac_x and frac_y changes mid-block have no effect.
  - rst mid-block aborts immediately to IDLE: out_valid drops, done is not pulsed, buffered rows are discarded.
  - start on the cycle done pulses is accepted; the block takes IDLE and start in the same cycle.
- busy is 1 in FILL, STREAM and DRAIN.

Test Plan:
- Uniform input: all pixels 128, every frac combination, BLK_W=BLK_H=8 -> every output pixel 128, 8 rows, done exactly once.
- Integer copy: frac 0/0, pixel j of row i = (16i+j) mod 256 -> out_row r column c = (16(r+3)+c+3) mod 256.
- Impulse, frac_x=2, frac_y=0: row 3 has 255 at index 3, all else 0 -> out row 0 column 0 = 159. With frac_x=1 the same pixel gives 231.
- Negative clip, frac_x=2, frac_y=0: 255 at row-3 index 2 (tap -11), all else 0 -> out row 0 column 0 = 0. The same stimulus with frac_x=2, frac_y=2 must also give 0.
- Back-pressure: out_ready low for 5 cycles mid-STREAM with in_valid held high -> in_ready=0 while stalled, out_row stable, no row lost or duplicated, output identical to the no-stall run.
- Reset abort: assert rst after 10 accepted rows -> next cycle out_valid=0, busy=0, no done pulse. A fresh start then produces a correct full block.
